f32m_cube_root: RTL
===================

// Module: f32m_cube_root
// PURPOSE
//  Inverse of the GF(3^{2m}) cubing stage: computes c = a^(1/3) for a = a0 + a1*s, s^2 = -1.
//  Uses c0 = a0^(1/3) and c1 = -(a1^(1/3)); cube root in GF(3^m) is x^(3^(m-1)).
//  Implemented as an iterative engine: 96 cubing passes over both coefficients, then a final negate of the high half.
//  Sits beside f32m_cubic in the Tate-pairing datapath (final exponentiation / Miller loop), driven by the pairing controller.
// PARAMETERS
//  M     97       field degree; fixed at 97 because the GF(3^m) cubing network is hard-wired for PX
//  ITER  M-1      number of cubing passes (96); counter width 7 bits
// PORTS
//  clk    in   1      rising-edge clock
//  reset  in   1      asynchronous, active-low reset (asserted when 0)
//  start  in   1      request; sampled only in IDLE
//  a      in   4M     operand {a1,a0}, each 2M bits, 2 bits per GF(3) digit, digit 0 at LSBs
//  c      out  4M     result {c1,c0}, registered; holds until the next result is written
//  busy   out  1      high from the edge that accepts start until the edge that writes c
//  done   out  1      one-cycle pulse: c is valid in this cycle
// BEHAVIOUR
//  - Digit encoding: 00=0, 01=1, 10=2; 11 is never produced; behaviour on 11 inputs is don't-care.
//  - Reset (reset=0, async): state=IDLE, cnt=0, working reg r=0, c=0, busy=0, done=0.
//  - States: IDLE, RUN, FIN.
//  - IDLE: when start=1 at edge E0: r<={a1,a0}, cnt<=0, busy<=1, state->RUN. Otherwise everything holds; done<=0.
//  - RUN: each edge: r<={cube(r_hi),cube(r_lo)}, cnt<=cnt+1. On the edge where cnt==ITER-1 (E96): state->FIN.
//  - FIN: at edge E97: c<={neg(r_hi),r_lo}, done<=1, busy<=0, state->IDLE.
//  - Latency: done is high in the cycle after E97, which is 97 clocks after start is sampled. Throughput is 1 result per 98 cycles (start at the first IDLE edge).
//  - start while busy=1 is ignored (no queueing); a is sampled only at E0. a may change afterwards.
//  - start in the same cycle as done is accepted: the engine is in IDLE, so a new run begins and done drops next cycle.
//  - Reset mid-run: the job is discarded; c is cleared to 0; no done pulse is produced.
//  - neg(x) swaps the two bits of each digit; cube(x) is the GF(3^m) Frobenius mod PX.
//  - No arithmetic carries; cnt never wraps because RUN exits at ITER-1.
// STRUCTURE
//  - Shared defines (existing include): M, WIDTH, W2, PX, ZERO. Add CR_ITER = M-1 alongside them.
//  - State encoding constants are local to this module.
//  - Datapath reuses the existing f3m_cubic (two instances, lo/hi) and f3m_neg (one instance on the output path).
//  - One new sub-module is natural: f32m_cube_root_ctrl (FSM + 7-bit counter, outputs load/step/fin).
//  - No multiplier or adder is required; the only F3 logic is in the reused instances.
// TESTING
//  1 a={ZERO, 1}: start -> done after 97 clocks, c0 = 1 (digit0=01), c1 = 0.
//  2 a={1, ZERO} (a1=1): -> c0 = 0, c1 = -1, i.e. digit0 of c1 = 10, all other digits 0.
//  3 Round trip: 1000 random valid a -> f32m_cubic(c) == a. Also feed f32m_cube_root with f32m_cubic(a) and check the result == a.
//  4 start held high for 300 cycles -> exactly 3 done pulses, spaced 98 cycles apart. Changing a while busy has no effect on c.
//  5 Drop reset at RUN cnt=50 -> busy, done and c go to 0 immediately. A new start then gives the correct result 97 clocks later.
//  6 start asserted in the done cycle -> second job accepted. Its done arrives 98 cycles after the first done.

Source files
------------

// File: rtl/f32m_cube_root_pkg.sv
// Shared constants and GF(3) digit helpers for the GF(3^2m) cube-root engine.
// Digits are 2 bits each: 00=0, 01=1, 10=2.
package f32m_cube_root_pkg;

  localparam int M       = 97;
  localparam int WIDTH   = 2 * M;
  localparam int W2      = 4 * M;
  localparam int CR_ITER = M - 1;
  localparam int CNT_W   = 7;

  // PX = x^97 + x^12 + 2, one 2-bit digit per power
  localparam int PX_TAP = 12;
  localparam logic [2*(M+1)-1:0] PX =
    {2'b01, 168'b0, 2'b01, 22'b0, 2'b10};

  localparam logic [WIDTH-1:0] ZERO = '0;

  function automatic logic [1:0] f3_neg(
    input logic [1:0] x
  );
    return {x[0], x[1]};
  endfunction

  function automatic logic [1:0] f3_add(
    input logic [1:0] x,
    input logic [1:0] y
  );
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [1:0] f3_mul(
    input logic [1:0] x,
    input logic [1:0] k
  );
    logic [1:0] r;
    r = 2'b00;
    if (k == 2'b01) r = x;
    else if (k == 2'b10) r = f3_neg(x);
    return r;
  endfunction

endpackage

// File: rtl/f32m_cube_root_ctrl.sv
// Sequencer for the cube-root engine: IDLE -> RUN (96 passes) -> FIN.
// Ports: clk, reset (async low), i_start; o_load/o_step/o_fin strobes, o_busy, o_done.
module f32m_cube_root_ctrl
  import f32m_cube_root_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  output logic o_load,
  output logic o_step,
  output logic o_fin,
  output logic o_busy,
  output logic o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_n;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_n;
  logic r_busy;
  logic r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_done  <= o_fin;
      if (o_load) r_busy <= 1'b1;
      else if (o_fin) r_busy <= 1'b0;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    o_load    = 1'b0;
    o_step    = 1'b0;
    o_fin     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          o_load    = 1'b1;
          w_cnt_n   = '0;
          w_state_n = S_RUN;
        end
      end
      S_RUN: begin
        o_step  = 1'b1;
        w_cnt_n = r_cnt + 7'd1;
        if (r_cnt == CNT_W'(CR_ITER - 1))
          w_state_n = S_FIN;
      end
      S_FIN: begin
        o_fin     = 1'b1;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/f3m_cubic.sv
// Frobenius map in GF(3^m): o_c = i_a^3 mod PX.
// Ports: i_a operand, o_c cube. Pure combinational network.
module f3m_cubic
  import f32m_cube_root_pkg::*;
(
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_c
);

  // x^M folds to K0 + KT*x^T (negated low terms of PX)
  localparam logic [1:0] K0 = f3_neg(PX[1:0]);
  localparam logic [1:0] KT = f3_neg(PX[2*PX_TAP +: 2]);

  function automatic logic [WIDTH-1:0] cube(
    input logic [WIDTH-1:0] x
  );
    logic [1:0] p [3*M-2];
    logic [1:0] t;
    logic [WIDTH-1:0] r;
    for (int k = 0; k < 3*M-2; k++) p[k] = 2'b00;
    // char 3: (sum a_i x^i)^3 = sum a_i x^(3i)
    for (int i = 0; i < M; i++) p[3*i] = x[2*i +: 2];
    // fold high powers down; targets stay below d
    for (int d = 3*M-3; d >= M; d--) begin
      t = p[d];
      p[d-M] = f3_add(p[d-M], f3_mul(t, K0));
      p[d-M+PX_TAP] =
        f3_add(p[d-M+PX_TAP], f3_mul(t, KT));
    end
    r = '0;
    for (int i = 0; i < M; i++) r[2*i +: 2] = p[i];
    return r;
  endfunction

  assign o_c = cube(i_a);

endmodule

// File: rtl/f3m_neg.sv
// Digit-wise negation in GF(3^m): swaps the two bits of every digit.
// Ports: i_a operand, o_c = -i_a.
module f3m_neg
  import f32m_cube_root_pkg::*;
(
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_c
);

  always_comb begin
    o_c = '0;
    for (int i = 0; i < M; i++)
      o_c[2*i +: 2] = f3_neg(i_a[2*i +: 2]);
  end

endmodule

// File: rtl/f32m_cube_root.sv
// GF(3^2m) cube root: c = {-(a1^(1/3)), a0^(1/3)} via 96 cubing passes.
// Ports: clk, reset (async low), start, a={a1,a0}; c={c1,c0}, busy, done.
module f32m_cube_root
  import f32m_cube_root_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W2-1:0] a,
  output logic [W2-1:0] c,
  output logic          busy,
  output logic          done
);

  logic w_load;
  logic w_step;
  logic w_fin;
  logic [W2-1:0] r_r;
  logic [W2-1:0] r_c;
  logic [WIDTH-1:0] w_cube_lo;
  logic [WIDTH-1:0] w_cube_hi;
  logic [WIDTH-1:0] w_neg_hi;

  f32m_cube_root_ctrl u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .i_start (start),
    .o_load  (w_load),
    .o_step  (w_step),
    .o_fin   (w_fin),
    .o_busy  (busy),
    .o_done  (done)
  );

  f3m_cubic u_cube_lo (
    .i_a (r_r[WIDTH-1:0]),
    .o_c (w_cube_lo)
  );

  f3m_cubic u_cube_hi (
    .i_a (r_r[W2-1:WIDTH]),
    .o_c (w_cube_hi)
  );

  f3m_neg u_neg_hi (
    .i_a (r_r[W2-1:WIDTH]),
    .o_c (w_neg_hi)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_r <= '0;
      r_c <= '0;
    end else begin
      if (w_load) r_r <= a;
      else if (w_step) r_r <= {w_cube_hi, w_cube_lo};
      if (w_fin) r_c <= {w_neg_hi, r_r[WIDTH-1:0]};
    end
  end

  assign c = r_c;

endmodule
